bit_deserializer: RTL

- Receive-side counterpart of the LSB-first serial bit stream used in this design.
- Captures framed single-bit bursts and packs them into W-bit words, LSB first.
- Marks the last word of each burst and reports the burst length in bits.
- Buffers words in a small FIFO with a valid/ready output handshake, so downstream packet logic can apply backpressure.

---
 rtl/bit_deserializer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/bit_deserializer.sv
// Serial-to-parallel receiver: packs framed LSB-first bit bursts into W-bit words,
// tags the final word of each burst and queues words in a first-word-fall-through FIFO.
module bit_deserializer #(
  parameter int W          = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic                      in_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [W-1:0]              m_data,
  output logic                      m_last,
  output logic [$clog2(W+1)-1:0]    m_nbits,
  output logic [32:0]               burst_len,
  output logic                      burst_done,
  output logic                      overflow
);

  localparam int CW  = $clog2(W);
  localparam int NBW = $clog2(W + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0]  CNT_MAX = CW'(W - 1);
  localparam logic [NBW-1:0] NB_FULL = NBW'(W);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  typedef struct packed {
    logic [W-1:0]   data;
    logic           last;
    logic [NBW-1:0] nbits;
  } word_t;

  state_t         state_q, state_d;
  logic           valid_d;
  logic [W-1:0]   shift_q, shift_d;
  logic [W-1:0]   hold_q, hold_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           held_q, held_d;
  logic [32:0]    len_q, len_d;
  logic           eob;
  logic           push;
  word_t          push_word;

  // A completed word waits in the holding register because its last flag is only
  // known once the next edge shows either another bit or the end of the burst.
  // NOTE: every signal written here gets a default first, so no latches are inferred.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    held_d    = held_q;
    len_d     = len_q;
    eob       = 1'b0;
    push      = 1'b0;
    push_word = '0;

    case (state_q)
      IDLE:    if (valid_d) state_d = ACTIVE;
      ACTIVE:  if (!valid_d) begin
                 state_d = IDLE;
                 eob     = 1'b1;
               end
      default: state_d = IDLE;
    endcase

    if (valid_d) begin
      len_d          = len_q + 33'd1;
      shift_d[cnt_q] = in_data;
      if (held_q) begin
        push      = 1'b1;
        push_word = '{data: hold_q, last: 1'b0, nbits: NB_FULL};
        held_d    = 1'b0;
      end
      if (cnt_q == CNT_MAX) begin
        hold_d  = shift_d;
        held_d  = 1'b1;
        shift_d = '0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (eob) begin
      if (held_q) begin
        push      = 1'b1;
        push_word = '{data: hold_q, last: 1'b1, nbits: NB_FULL};
      end else if (cnt_q != '0) begin
        push      = 1'b1;
        push_word = '{data: shift_q, last: 1'b1, nbits: NBW'(cnt_q)};
      end
      held_d  = 1'b0;
      cnt_d   = '0;
      shift_d = '0;
      len_d   = '0;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_d    <= 1'b0;
      state_q    <= IDLE;
      shift_q    <= '0;
      hold_q     <= '0;
      cnt_q      <= '0;
      held_q     <= 1'b0;
      len_q      <= '0;
      burst_len  <= '0;
      burst_done <= 1'b0;
    end else begin
      valid_d    <= in_valid;
      state_q    <= state_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      cnt_q      <= cnt_d;
      held_q     <= held_d;
      len_q      <= len_d;
      burst_done <= eob;
      if (eob) burst_len <= len_q;
    end
  end

  // Output FIFO: pointers carry one extra wrap bit to tell full from empty.
  word_t          mem [FIFO_DEPTH];
  word_t          head;
  logic [AW:0]    wr_ptr, rd_ptr;
  logic           empty, full, pop, wr_en, drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && m_ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (drop)  overflow <= 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_word;
  end

  always_comb begin
    head = '0;
    if (!empty) head = mem[rd_ptr[AW-1:0]];
  end

  assign m_valid = !empty;
  assign m_data  = head.data;
  assign m_last  = head.last;
  assign m_nbits = head.nbits;

endmodule
